// File: rtl/wb_pipe_pkg.sv
// Shared types and helpers for the elastic write-back pipeline register.
// Default widths here seed the parameters of wb_pipe_regs.
package wb_pipe_pkg;

    localparam int WB_DATA_WIDTH        = 64;
    localparam int WB_REG_INDEX_BITS    = 5;
    localparam int WB_THREAD_INDEX_BITS = 3;
    localparam int DEPTH_MAX            = 8;

    typedef struct packed {
        logic                            write_back_flag;
        logic [WB_REG_INDEX_BITS-1:0]    reg_index;
        logic [WB_THREAD_INDEX_BITS-1:0] thread_index;
        logic [WB_DATA_WIDTH-1:0]        data;
    } wb_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_pipe_slot.sv
// One stage of the write-back pipeline: a valid bit plus an opaque payload.
// kill qualifies whatever entry the slot will hold after this edge.
module wb_pipe_slot
    import wb_pipe_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance_out,
    input  logic             kill,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= !kill;
            q     <= d;
        end else if (advance_out || kill) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_pipe_regs.sv
// Elastic DEPTH-stage write-back pipeline with bubble collapsing, per-thread
// flush and forwarding lookup. Optional stall counter: WB_PIPE_STALL_CNT_EN.
module wb_pipe_regs
    import wb_pipe_pkg::*;
#(
    parameter int DATA_WIDTH        = WB_DATA_WIDTH,
    parameter int REG_INDEX_BITS    = WB_REG_INDEX_BITS,
    parameter int THREAD_INDEX_BITS = WB_THREAD_INDEX_BITS,
    parameter int DEPTH             = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_write_back_flag,
    input  logic [REG_INDEX_BITS-1:0]     in_reg_index,
    input  logic [THREAD_INDEX_BITS-1:0]  in_thread_index,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_write_back_flag,
    output logic [REG_INDEX_BITS-1:0]     out_reg_index,
    output logic [THREAD_INDEX_BITS-1:0]  out_thread_index,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          flush_valid,
    input  logic [THREAD_INDEX_BITS-1:0]  flush_thread_index,
    input  logic [REG_INDEX_BITS-1:0]     fwd_reg_index,
    input  logic [THREAD_INDEX_BITS-1:0]  fwd_thread_index,
    output logic                          fwd_hit,
    output logic [DATA_WIDTH-1:0]         fwd_data,
`ifdef WB_PIPE_STALL_CNT_EN
    input  logic                          stall_count_clr,
    output logic [31:0]                   stall_count,
`endif
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    typedef struct packed {
        logic                         write_back_flag;
        logic [REG_INDEX_BITS-1:0]    reg_index;
        logic [THREAD_INDEX_BITS-1:0] thread_index;
        logic [DATA_WIDTH-1:0]        data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("wb_pipe_regs: DEPTH out of range");
    end

    entry_t             in_entry;
    entry_t             src   [DEPTH];
    entry_t             stage [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   adv;
    logic [DEPTH-1:0]   load;
    logic [DEPTH-1:0]   kill;

    assign in_entry = '{write_back_flag: in_write_back_flag,
                        reg_index:       in_reg_index,
                        thread_index:    in_thread_index,
                        data:            in_data};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_src_in
            assign src[i] = in_entry;
        end else begin : g_src_prev
            assign src[i] = stage[i-1];
        end

        wb_pipe_slot #(.WIDTH(ENTRY_W)) u_slot (
            .clk         (clk),
            .reset       (reset),
            .load        (load[i]),
            .advance_out (adv[i]),
            .kill        (kill[i]),
            .d           (src[i]),
            .valid       (valid[i]),
            .q           (stage[i])
        );
    end

    // Advance chain runs oldest-to-youngest so holes are filled in one cycle.
    always_comb begin
        adv      = '0;
        load     = '0;
        kill     = '0;
        in_ready = 1'b0;
        adv[DEPTH-1] = valid[DEPTH-1] && out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = valid[i] && (!valid[i+1] || adv[i+1]);
        end
        in_ready = !valid[0] || adv[0];
        load[0]  = in_valid && in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = adv[i-1];
        end
        // Flush compares against the entry the slot will hold after the edge.
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = flush_valid &&
                      ((load[i] ? src[i].thread_index : stage[i].thread_index)
                       == flush_thread_index);
        end
    end

    // Scan oldest first so the youngest match overwrites.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && stage[i].write_back_flag &&
                stage[i].reg_index == fwd_reg_index &&
                stage[i].thread_index == fwd_thread_index) begin
                fwd_hit  = 1'b1;
                fwd_data = stage[i].data;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

    assign out_valid           = valid[DEPTH-1];
    assign out_write_back_flag = stage[DEPTH-1].write_back_flag;
    assign out_reg_index       = stage[DEPTH-1].reg_index;
    assign out_thread_index    = stage[DEPTH-1].thread_index;
    assign out_data            = stage[DEPTH-1].data;

`ifdef WB_PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || stall_count_clr) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && stall_count != 32'hFFFF_FFFF) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_regs.sv
// Directed self-checking bench for wb_pipe_regs at DEPTH=2 and DEPTH=3.
// Stall-counter checks compile in when WB_PIPE_STALL_CNT_EN is defined.
module tb_wb_pipe_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_wbf, out_ready, flush_valid;
    logic [4:0]  in_reg, fwd_reg;
    logic [2:0]  in_thr, flush_thr, fwd_thr;
    logic [63:0] in_data;

    logic        rdy2, ov2, owbf2, hit2;
    logic [4:0]  oreg2;
    logic [2:0]  othr2;
    logic [63:0] odata2, fdata2;
    logic [1:0]  occ2;

    logic        rdy3, ov3, owbf3, hit3;
    logic [4:0]  oreg3;
    logic [2:0]  othr3;
    logic [63:0] odata3, fdata3;
    logic [1:0]  occ3;

`ifdef WB_PIPE_STALL_CNT_EN
    logic        stall_clr;
    logic [31:0] sc2, sc3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_pipe_regs #(.DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy2),
        .in_write_back_flag(in_wbf), .in_reg_index(in_reg),
        .in_thread_index(in_thr), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready),
        .out_write_back_flag(owbf2), .out_reg_index(oreg2),
        .out_thread_index(othr2), .out_data(odata2),
        .flush_valid(flush_valid), .flush_thread_index(flush_thr),
        .fwd_reg_index(fwd_reg), .fwd_thread_index(fwd_thr),
        .fwd_hit(hit2), .fwd_data(fdata2),
`ifdef WB_PIPE_STALL_CNT_EN
        .stall_count_clr(stall_clr), .stall_count(sc2),
`endif
        .occupancy(occ2)
    );

    wb_pipe_regs #(.DEPTH(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy3),
        .in_write_back_flag(in_wbf), .in_reg_index(in_reg),
        .in_thread_index(in_thr), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready),
        .out_write_back_flag(owbf3), .out_reg_index(oreg3),
        .out_thread_index(othr3), .out_data(odata3),
        .flush_valid(flush_valid), .flush_thread_index(flush_thr),
        .fwd_reg_index(fwd_reg), .fwd_thread_index(fwd_thr),
        .fwd_hit(hit3), .fwd_data(fdata3),
`ifdef WB_PIPE_STALL_CNT_EN
        .stall_count_clr(stall_clr), .stall_count(sc3),
`endif
        .occupancy(occ3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wbf, input logic [4:0] r,
                         input logic [2:0] t, input logic [63:0] d);
        in_valid = v;
        in_wbf   = wbf;
        in_reg   = r;
        in_thr   = t;
        in_data  = d;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        out_ready   = 1'b0;
        flush_valid = 1'b0;
        flush_thr   = 3'd0;
        fwd_reg     = 5'd0;
        fwd_thr     = 3'd0;
`ifdef WB_PIPE_STALL_CNT_EN
        stall_clr   = 1'b0;
`endif
        drive(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ov2 !== 1'b0 || ov3 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b/%b exp=0", ov2, ov3); end
        checks++; if (occ2 !== 2'd0 || occ3 !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d/%0d exp=0", occ2, occ3); end
        checks++; if (rdy2 !== 1'b1 || rdy3 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b/%b exp=1", rdy2, rdy3); end
        checks++; if (odata3 !== 64'd0 || oreg3 !== 5'd0 || othr3 !== 3'd0 || owbf3 !== 1'b0) begin failures++; $display("FAIL reset_payload got=%0h exp=0", odata3); end
        checks++; if (hit3 !== 1'b0 || fdata3 !== 64'd0) begin failures++; $display("FAIL reset_fwd got=%b/%0h exp=0/0", hit3, fdata3); end
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 3'd2, 64'hAA);
        #1;
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b exp=1", rdy2); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (occ2 !== 2'd1 || ov2 !== 1'b0) begin failures++; $display("FAIL lat_cycle1 got occ=%0d ov=%b exp occ=1 ov=0", occ2, ov2); end
        tick();
        checks++; if (ov2 !== 1'b1 || occ2 !== 2'd1) begin failures++; $display("FAIL lat_cycle2 got ov=%b occ=%0d exp ov=1 occ=1", ov2, occ2); end
        checks++; if (oreg2 !== 5'd5 || othr2 !== 3'd2 || odata2 !== 64'hAA || owbf2 !== 1'b1) begin failures++; $display("FAIL lat_payload got r=%0d t=%0d d=%0h w=%b exp r=5 t=2 d=aa w=1", oreg2, othr2, odata2, owbf2); end
        tick();
        checks++; if (ov2 !== 1'b0 || occ2 !== 2'd0) begin failures++; $display("FAIL lat_drain got ov=%b occ=%0d exp 0/0", ov2, occ2); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b1, 1'b1, 5'(k), 3'd1, 64'h200 + 64'(k));
            else       in_valid = 1'b0;
            #1;
            if (k < 4) begin
                checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, rdy2); end
            end
            if (k >= 2) begin
                checks++; if (ov2 !== 1'b1 || odata2 !== 64'h200 + 64'(k - 2)) begin failures++; $display("FAIL b2b_out k=%0d got ov=%b d=%0h exp ov=1 d=%0h", k, ov2, odata2, 64'h200 + 64'(k - 2)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int idx;
        logic acc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 5'(k), 3'd0, 64'h100 + 64'(k));
            #1;
            checks++; if (rdy3 !== (k < 3)) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, rdy3, (k < 3)); end
            tick();
        end
        #1;
        checks++; if (occ3 !== 2'd3 || rdy3 !== 1'b0) begin failures++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=3 rdy=0", occ3, rdy3); end
        checks++; if (ov3 !== 1'b1 || odata3 !== 64'h100) begin failures++; $display("FAIL bp_head got ov=%b d=%0h exp ov=1 d=100", ov3, odata3); end
        tick();
        tick();
        checks++; if (odata3 !== 64'h100 || oreg3 !== 5'd0 || occ3 !== 2'd3) begin failures++; $display("FAIL bp_stable got d=%0h r=%0d occ=%0d exp d=100 r=0 occ=3", odata3, oreg3, occ3); end
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ov3) begin
                checks++; if (odata3 !== 64'h100 + 64'(idx)) begin failures++; $display("FAIL bp_order idx=%0d got=%0h exp=%0h", idx, odata3, 64'h100 + 64'(idx)); end
                idx++;
            end
            acc = in_valid && rdy3;
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (idx !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", idx); end
        checks++; if (occ3 !== 2'd0) begin failures++; $display("FAIL bp_empty got occ=%0d exp=0", occ3); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b1, 5'd1, 3'd1, 64'h31); tick();
        drive(1'b1, 1'b1, 5'd2, 3'd3, 64'h32); tick();
        drive(1'b1, 1'b1, 5'd3, 3'd1, 64'h33); tick();
        in_valid    = 1'b0;
        flush_valid = 1'b1;
        flush_thr   = 3'd1;
        #1;
        checks++; if (occ3 !== 2'd3) begin failures++; $display("FAIL flush_pre got occ=%0d exp=3", occ3); end
        tick();
        flush_valid = 1'b0;
        #1;
        checks++; if (occ3 !== 2'd1 || ov3 !== 1'b0) begin failures++; $display("FAIL flush_after got occ=%0d ov=%b exp occ=1 ov=0", occ3, ov3); end
        tick();
        checks++; if (ov3 !== 1'b1 || othr3 !== 3'd3 || odata3 !== 64'h32 || occ3 !== 2'd1) begin failures++; $display("FAIL flush_collapse got ov=%b t=%0d d=%0h occ=%0d exp ov=1 t=3 d=32 occ=1", ov3, othr3, odata3, occ3); end
    endtask

    task automatic test_flush_handshake();
        int extra;
        do_reset();
        drive(1'b1, 1'b1, 5'd4, 3'd4, 64'h44);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (ov3 !== 1'b1 || othr3 !== 3'd4) begin failures++; $display("FAIL fh_setup got ov=%b t=%0d exp ov=1 t=4", ov3, othr3); end
        out_ready   = 1'b1;
        flush_valid = 1'b1;
        flush_thr   = 3'd4;
        drive(1'b1, 1'b1, 5'd6, 3'd4, 64'h45);
        #1;
        checks++; if (rdy3 !== 1'b1 || odata3 !== 64'h44) begin failures++; $display("FAIL fh_handshake got rdy=%b d=%0h exp rdy=1 d=44", rdy3, odata3); end
        tick();
        flush_valid = 1'b0;
        in_valid    = 1'b0;
        #1;
        checks++; if (occ3 !== 2'd0) begin failures++; $display("FAIL fh_occupancy got=%0d exp=0", occ3); end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (ov3) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL fh_no_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(1'b1, 1'b1, 5'd7, 3'd0, 64'h11); tick();
        drive(1'b1, 1'b1, 5'd8, 3'd0, 64'h44); tick();
        drive(1'b1, 1'b1, 5'd7, 3'd0, 64'h22); tick();
        in_valid = 1'b0;
        fwd_reg = 5'd7; fwd_thr = 3'd0;
        #1;
        checks++; if (hit3 !== 1'b1 || fdata3 !== 64'h22) begin failures++; $display("FAIL fwd_youngest got hit=%b d=%0h exp hit=1 d=22", hit3, fdata3); end
        fwd_reg = 5'd8;
        #1;
        checks++; if (hit3 !== 1'b1 || fdata3 !== 64'h44) begin failures++; $display("FAIL fwd_reg8 got hit=%b d=%0h exp hit=1 d=44", hit3, fdata3); end
        fwd_reg = 5'd7; fwd_thr = 3'd1;
        #1;
        checks++; if (hit3 !== 1'b0 || fdata3 !== 64'd0) begin failures++; $display("FAIL fwd_thread_miss got hit=%b d=%0h exp hit=0 d=0", hit3, fdata3); end
        do_reset();
        drive(1'b1, 1'b0, 5'd9, 3'd2, 64'h33); tick();
        drive(1'b1, 1'b0, 5'd9, 3'd2, 64'h34); tick();
        in_valid = 1'b0;
        fwd_reg = 5'd9; fwd_thr = 3'd2;
        #1;
        checks++; if (occ3 !== 2'd2 || hit3 !== 1'b0 || fdata3 !== 64'd0) begin failures++; $display("FAIL fwd_no_wb got occ=%0d hit=%b d=%0h exp occ=2 hit=0 d=0", occ3, hit3, fdata3); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'(k), 3'd5, 64'h50 + 64'(k));
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (occ3 !== 2'd3) begin failures++; $display("FAIL mid_loaded got occ=%0d exp=3", occ3); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (ov3 !== 1'b0 || occ3 !== 2'd0 || rdy3 !== 1'b1 || odata3 !== 64'd0) begin failures++; $display("FAIL mid_reset got ov=%b occ=%0d rdy=%b d=%0h exp 0/0/1/0", ov3, occ3, rdy3, odata3); end
`ifdef WB_PIPE_STALL_CNT_EN
        checks++; if (sc3 !== 32'd0) begin failures++; $display("FAIL stall_reset got=%0d exp=0", sc3); end
        drive(1'b1, 1'b1, 5'd1, 3'd1, 64'h77);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (ov3 !== 1'b1 || sc3 !== 32'd0) begin failures++; $display("FAIL stall_start got ov=%b cnt=%0d exp ov=1 cnt=0", ov3, sc3); end
        for (int c = 0; c < 5; c++) tick();
        checks++; if (sc3 !== 32'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", sc3); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (sc3 !== 32'd0) begin failures++; $display("FAIL stall_clr got=%0d exp=0", sc3); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_flush_handshake();
        test_forwarding();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
